voice_fetch: RTL and testbench

Per-voice sample prefetcher on the playback side of `storagectl`. It captures the sample start-address table streamed out on `update`/`start_a`, and turns voice triggers into a round-robin stream of single-word RAM read requests (`playback_req_available`/`playback_a`/`r_id_in`). It steers the tagged responses (`audio_data_ready`/`audio_out`/`r_id_out`) into small per-voice buffers, then presents one sample per voice per audio `sample_tick` to the mixer.

---
 rtl/voice_fetch_pkg.sv | 14 +
 rtl/voice_fifo.sv | 82 ++++++++
 rtl/voice_fetch.sv | 275 +++++++++++++++++++++++++++
 tb/tb_voice_fetch.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_fetch_pkg.sv
// Shared constants and FSM encodings for the per-voice sample prefetcher.
// Imported by voice_fetch and voice_fifo.
package voice_fetch_pkg;

  localparam int REQ_ID_U = 1;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/voice_fifo.sv
// Small per-voice sample buffer: circular store with push, pop, flush and occupancy.
// The head word is presented combinationally so the owner can register it on a pop.
module voice_fifo
  import voice_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = SAMPLE_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    push_ok  = 1'b0;
    pop_ok   = 1'b0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      pop_ok  = pop && (count_q != '0);
      // A simultaneous pop frees the slot the push needs when full.
      push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/voice_fetch.sv
// Per-voice sample prefetcher: captures the slot address table, issues round-robin
// single-word reads with one outstanding request, and feeds per-voice buffers to the mixer.
module voice_fetch
  import voice_fetch_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NUM_SLOTS  = 8,
  parameter int ID_W       = 2,
  parameter int ADDR_W     = 27,
  parameter int BUF_DEPTH  = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           update,
  input  logic [ADDR_W-1:0]              start_a,
  input  logic                           trig,
  input  logic [ID_W-1:0]                trig_voice,
  input  logic [$clog2(NUM_SLOTS)-1:0]   trig_slot,
  input  logic                           sample_tick,
  output logic                           playback_req_available,
  output logic [ADDR_W-1:0]              playback_a,
  output logic [ID_W-1:0]                r_id_in,
  input  logic                           audio_data_ready,
  input  logic signed [SAMPLE_W-1:0]     audio_out,
  input  logic [ID_W-1:0]                r_id_out,
  output logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  output logic [NUM_VOICES-1:0]          voice_active,
  output logic [NUM_VOICES-1:0]          underrun,
  output logic [1:0]                     dbg_state
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int TBL_W  = $clog2(NUM_SLOTS + 1);
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  // Start-address table and its load counter.
  logic [ADDR_W-1:0] table_q [NUM_SLOTS+1];
  logic [ADDR_W-1:0] table_d [NUM_SLOTS+1];
  logic [TBL_W-1:0]  wr_cnt_q, wr_cnt_d, wr_idx;
  logic              update_prev_q;
  logic [TBL_W-1:0]  slot_lo, slot_hi;

  // Per-voice playback state.
  logic [ADDR_W-1:0]         fetch_addr_q [NUM_VOICES];
  logic [ADDR_W-1:0]         fetch_addr_d [NUM_VOICES];
  logic [ADDR_W-1:0]         end_addr_q   [NUM_VOICES];
  logic [ADDR_W-1:0]         end_addr_d   [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] sample_q    [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] sample_d    [NUM_VOICES];
  logic [NUM_VOICES-1:0]     active_q, active_d;
  logic [NUM_VOICES-1:0]     underrun_q, underrun_d;
  logic [NUM_VOICES-1:0]     kill_q, kill_d;
  logic [NUM_VOICES-1:0]     trig_hit;
  logic [NUM_VOICES-1:0]     elig;

  // Buffer interface.
  logic [NUM_VOICES-1:0]     fifo_push, fifo_pop, fifo_flush;
  logic [SAMPLE_W-1:0]       fifo_head  [NUM_VOICES];
  logic [CNT_W-1:0]          fifo_count [NUM_VOICES];

  // Fetch FSM and request outputs.
  fetch_state_e      state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   pend_q, pend_d;
  logic [ID_W-1:0]   cand, gnt;
  logic              found;
  logic              discard_q, discard_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] req_a_q, req_a_d;
  logic [ID_W-1:0]   req_id_q, req_id_d;

  // A new burst (update after a low cycle) always restarts at entry 0.
  always_comb begin
    table_d  = table_q;
    wr_cnt_d = wr_cnt_q;
    wr_idx   = (update && !update_prev_q) ? '0 : wr_cnt_q;
    if (update) begin
      table_d[wr_idx] = start_a;
      wr_cnt_d = (wr_idx == TBL_W'(NUM_SLOTS)) ? '0 : wr_idx + TBL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= NUM_SLOTS; i++) begin
        table_q[i] <= '0;
      end
      wr_cnt_q      <= '0;
      update_prev_q <= 1'b0;
    end else begin
      table_q       <= table_d;
      wr_cnt_q      <= wr_cnt_d;
      update_prev_q <= update;
    end
  end

  assign slot_lo = TBL_W'(trig_slot);
  assign slot_hi = slot_lo + TBL_W'(1);

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      trig_hit[v] = trig && (trig_voice == ID_W'(v));
    end
  end

  // Voice bookkeeping: a trigger overrides any tick or fetch advance on that voice.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      fetch_addr_d[v] = fetch_addr_q[v];
      end_addr_d[v]   = end_addr_q[v];
      sample_d[v]     = sample_q[v];
      active_d[v]     = active_q[v];
      underrun_d[v]   = underrun_q[v];
      kill_d[v]       = 1'b0;
      fifo_pop[v]     = 1'b0;
      fifo_flush[v]   = 1'b0;
      if (trig_hit[v]) begin
        fetch_addr_d[v] = table_q[slot_lo];
        end_addr_d[v]   = table_q[slot_hi];
        active_d[v]     = 1'b1;
        underrun_d[v]   = 1'b0;
        fifo_flush[v]   = 1'b1;
        kill_d[v]       = (table_q[slot_lo] >= table_q[slot_hi]);
      end else begin
        if ((state_q == ST_ISSUE) && (pend_q == ID_W'(v))) begin
          fetch_addr_d[v] = fetch_addr_q[v] + ADDR_W'(1);
        end
        if (kill_q[v]) begin
          active_d[v] = 1'b0;
        end
        if (sample_tick) begin
          if (!active_q[v]) begin
            sample_d[v] = '0;
          end else if (fifo_count[v] != '0) begin
            fifo_pop[v] = 1'b1;
            sample_d[v] = fifo_head[v];
          end else if (fetch_addr_q[v] < end_addr_q[v]) begin
            sample_d[v]   = '0;
            underrun_d[v] = 1'b1;
          end else begin
            sample_d[v] = '0;
            active_d[v] = 1'b0;
          end
        end
      end
    end
  end

  // Fetch FSM: round-robin grant in IDLE, one request cycle, then wait for the tagged reply.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    pend_d    = pend_q;
    discard_d = discard_q;
    timer_d   = timer_q;
    req_d     = 1'b0;
    req_a_d   = '0;
    req_id_d  = '0;
    fifo_push = '0;
    found     = 1'b0;
    gnt       = rr_q;
    cand      = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      elig[v] = active_q[v] && (fetch_addr_q[v] < end_addr_q[v]) &&
                (fifo_count[v] < CNT_W'(BUF_DEPTH)) && !trig_hit[v] && !kill_q[v];
    end
    for (int i = 1; i <= NUM_VOICES; i++) begin
      cand = rr_q + ID_W'(i);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d   = ST_ISSUE;
          rr_d      = gnt;
          pend_d    = gnt;
          discard_d = 1'b0;
          req_d     = 1'b1;
          req_a_d   = fetch_addr_q[gnt];
          req_id_d  = gnt;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        timer_d = '0;
        if (trig_hit[pend_q]) begin
          discard_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (trig_hit[pend_q]) begin
          discard_d = 1'b1;
        end
        if (audio_data_ready && (r_id_out == pend_q)) begin
          fifo_push[pend_q] = !discard_q && !trig_hit[pend_q];
          state_d           = ST_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          // Abandon the word; fetch_addr has already moved past it.
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        fetch_addr_q[v] <= '0;
        end_addr_q[v]   <= '0;
        sample_q[v]     <= '0;
      end
      active_q   <= '0;
      underrun_q <= '0;
      kill_q     <= '0;
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      pend_q     <= '0;
      discard_q  <= 1'b0;
      timer_q    <= '0;
      req_q      <= 1'b0;
      req_a_q    <= '0;
      req_id_q   <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      end_addr_q   <= end_addr_d;
      sample_q     <= sample_d;
      active_q     <= active_d;
      underrun_q   <= underrun_d;
      kill_q       <= kill_d;
      state_q      <= state_d;
      rr_q         <= rr_d;
      pend_q       <= pend_d;
      discard_q    <= discard_d;
      timer_q      <= timer_d;
      req_q        <= req_d;
      req_a_q      <= req_a_d;
      req_id_q     <= req_id_d;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_fifo #(
      .DEPTH (BUF_DEPTH),
      .W     (SAMPLE_W),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (fifo_flush[v]),
      .push      (fifo_push[v]),
      .push_data (audio_out),
      .pop       (fifo_pop[v]),
      .pop_data  (fifo_head[v]),
      .count     (fifo_count[v])
    );
    assign voice_sample[SAMPLE_W*v +: SAMPLE_W] = sample_q[v];
  end

  assign playback_req_available = req_q;
  assign playback_a             = req_a_q;
  assign r_id_in                = req_id_q;
  assign voice_active           = active_q;
  assign underrun               = underrun_q;
  assign dbg_state              = state_q;

endmodule

// File: tb/tb_voice_fetch.sv
// Directed bench for voice_fetch: table load, round-robin fetch, timeout, underrun,
// retrigger discard and mid-transaction reset, against a latency-programmable RAM model.
module tb_voice_fetch;
  import voice_fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic        update;
  logic [26:0] start_a;
  logic        trig;
  logic [1:0]  trig_voice;
  logic [2:0]  trig_slot;
  logic        sample_tick;
  logic        playback_req_available;
  logic [26:0] playback_a;
  logic [1:0]  r_id_in;
  logic        audio_data_ready;
  logic signed [15:0] audio_out;
  logic [1:0]  r_id_out;
  logic [63:0] voice_sample;
  logic [3:0]  voice_active;
  logic [3:0]  underrun;
  logic [1:0]  dbg_state;

  voice_fetch dut (
    .clk                    (clk),
    .reset                  (reset),
    .update                 (update),
    .start_a                (start_a),
    .trig                   (trig),
    .trig_voice             (trig_voice),
    .trig_slot              (trig_slot),
    .sample_tick            (sample_tick),
    .playback_req_available (playback_req_available),
    .playback_a             (playback_a),
    .r_id_in                (r_id_in),
    .audio_data_ready       (audio_data_ready),
    .audio_out              (audio_out),
    .r_id_out               (r_id_out),
    .voice_sample           (voice_sample),
    .voice_active           (voice_active),
    .underrun               (underrun),
    .dbg_state              (dbg_state)
  );

  // ---- clock/reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_lat = 1;

  logic [26:0] tbl [9] = '{27'h100, 27'h104, 27'h110, 27'h120, 27'h120,
                           27'h130, 27'h140, 27'h150, 27'h160};

  typedef struct {
    int          due;
    logic [26:0] a;
    logic [1:0]  id;
  } resp_t;

  resp_t       resp_q[$];
  logic [26:0] req_a_log[$];
  logic [1:0]  req_id_log[$];
  int          req_cyc_log[$];

  function automatic logic [15:0] mdata(input logic [26:0] a);
    return 16'hC000 | {4'h0, a[11:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- RAM model: logs requests, answers each after resp_lat cycles ----
  always @(negedge clk) begin
    if (reset && playback_req_available) begin
      req_a_log.push_back(playback_a);
      req_id_log.push_back(r_id_in);
      req_cyc_log.push_back(cyc);
      resp_q.push_back('{cyc + resp_lat, playback_a, r_id_in});
    end
  end

  initial begin
    audio_data_ready = 1'b0;
    audio_out        = '0;
    r_id_out         = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      audio_data_ready = 1'b0;
      for (int i = 0; i < resp_q.size(); i++) begin
        if (resp_q[i].due <= cyc) begin
          audio_data_ready = 1'b1;
          audio_out        = mdata(resp_q[i].a);
          r_id_out         = resp_q[i].id;
          resp_q.delete(i);
          break;
        end
      end
    end
  end

  // ---- driver tasks (all start and end 1 time unit after a rising edge) ----
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_a_log.delete();
    req_id_log.delete();
    req_cyc_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    resp_q.delete();
    clear_logs();
    step(1);
  endtask

  task automatic load_table();
    for (int i = 0; i < 9; i++) begin
      update  = 1'b1;
      start_a = tbl[i];
      step(1);
    end
    update = 1'b0;
    step(1);
  endtask

  task automatic trigger(input logic [1:0] v, input logic [2:0] s);
    trig       = 1'b1;
    trig_voice = v;
    trig_slot  = s;
    step(1);
    trig = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic wait_reqs(input string tag, input int n, input int budget);
    int k = 0;
    while (req_a_log.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 64'(req_a_log.size() >= n), 64'd1);
  endtask

  // ---- directed sequences ----
  initial begin
    int gap;
    int v2_reqs;
    reset = 1'b0; update = 1'b0; start_a = '0; trig = 1'b0;
    trig_voice = '0; trig_slot = '0; sample_tick = 1'b0;
    step(2);
    check("rst_active", 64'(voice_active), 64'd0);
    check("rst_sample", voice_sample, 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_req", 64'(playback_req_available), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b1;
    step(1);

    // Basic playback of slot 0 on voice 0, after an aborted partial burst.
    for (int i = 0; i < 3; i++) begin
      update = 1'b1; start_a = 27'h777; step(1);
    end
    update = 1'b0;
    step(2);
    load_table();
    resp_lat = 1;
    trigger(2'd0, 3'd0);
    check("t1_active_next", 64'(voice_active), 64'b0001);
    step(1);
    check("t1_req_latency", 64'(playback_req_available), 64'd1);
    check("t1_req_addr0", 64'(playback_a), 64'h100);
    check("t1_req_id0", 64'(r_id_in), 64'd0);
    wait_reqs("t1_wait2", 2, 50);
    step(10);
    check("t1_depth_limit", 64'(req_a_log.size()), 64'd2);
    check("t1_addr1", 64'(req_a_log[1]), 64'h101);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t1_sample%0d", k), 64'(voice_sample[15:0]), 64'(mdata(27'h100 + 27'(k))));
      step(10);
    end
    check("t1_total_reqs", 64'(req_a_log.size()), 64'd4);
    check("t1_last_addr", 64'(req_a_log[3]), 64'h103);
    tick();
    check("t1_end_active", 64'(voice_active), 64'd0);
    check("t1_end_sample", 64'(voice_sample[15:0]), 64'd0);
    check("t1_no_underrun", 64'(underrun), 64'd0);

    // Round-robin between voices 0 and 1.
    do_reset();
    load_table();
    resp_lat = 1;
    trigger(2'd0, 3'd0);
    trigger(2'd1, 3'd1);
    wait_reqs("t2_wait4", 4, 100);
    step(20);
    check("t2_req_count", 64'(req_a_log.size()), 64'd4);
    check("t2_ids", 64'({req_id_log[0], req_id_log[1], req_id_log[2], req_id_log[3]}), 64'b00_01_00_01);
    check("t2_addr1", 64'(req_a_log[1]), 64'h104);
    check("t2_addr3", 64'(req_a_log[3]), 64'h105);
    tick();
    check("t2_sample_v0", 64'(voice_sample[15:0]), 64'hC100);
    check("t2_sample_v1", 64'(voice_sample[31:16]), 64'hC104);

    // Timeout on a 300-cycle response; the word is skipped and the late reply ignored.
    do_reset();
    load_table();
    resp_lat = 300;
    trigger(2'd3, 3'd2);
    wait_reqs("t3_wait1", 1, 10);
    resp_lat = 1;
    wait_reqs("t3_wait3", 3, 400);
    step(60);
    gap = req_cyc_log[1] - req_cyc_log[0];
    check("t3_timeout_gap", 64'(gap >= 256 && gap <= 258), 64'd1);
    check("t3_req_count", 64'(req_a_log.size()), 64'd3);
    check("t3_addr1", 64'(req_a_log[1]), 64'h111);
    check("t3_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    check("t3_skip_sample", 64'(voice_sample[63:48]), 64'hC111);
    tick();
    check("t3_next_sample", 64'(voice_sample[63:48]), 64'hC112);

    // Underrun with slow responses, cleared by retrigger.
    do_reset();
    load_table();
    resp_lat = 10;
    trigger(2'd0, 3'd1);
    step(3);
    tick();
    check("t4_underrun", 64'(underrun), 64'b0001);
    check("t4_sample_zero", 64'(voice_sample[15:0]), 64'd0);
    trigger(2'd0, 3'd0);
    check("t4_underrun_clr", 64'(underrun), 64'd0);

    // Retrigger voice 2 during WAIT: reply dropped, next request uses the new slot.
    do_reset();
    load_table();
    resp_lat = 20;
    trigger(2'd2, 3'd0);
    wait_reqs("t5_wait1", 1, 10);
    step(3);
    trigger(2'd2, 3'd2);
    wait_reqs("t5_wait2", 2, 60);
    check("t5_new_addr", 64'(req_a_log[1]), 64'h110);
    check("t5_new_id", 64'(req_id_log[1]), 64'd2);
    tick();
    check("t5_buf_empty", 64'(underrun[2]), 64'd1);
    check("t5_sample_zero", 64'(voice_sample[47:32]), 64'd0);
    step(25);
    tick();
    check("t5_sample_new", 64'(voice_sample[47:32]), 64'hC110);

    // Reset pulsed mid-WAIT, late reply ignored, then normal playback.
    do_reset();
    load_table();
    resp_lat = 50;
    trigger(2'd1, 3'd0);
    wait_reqs("t6_wait1", 1, 10);
    step(5);
    reset = 1'b0;
    #2;
    check("t6_rst_active", 64'(voice_active), 64'd0);
    check("t6_rst_sample", voice_sample, 64'd0);
    check("t6_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    step(2);
    reset = 1'b1;
    clear_logs();
    step(1);
    load_table();
    step(60);
    check("t6_late_active", 64'(voice_active), 64'd0);
    check("t6_late_state", 64'(dbg_state), 64'(ST_IDLE));
    resp_lat = 1;
    trigger(2'd1, 3'd0);
    wait_reqs("t6_wait2", 2, 30);
    check("t6_addr0", 64'(req_a_log[0]), 64'h100);
    check("t6_id0", 64'(req_id_log[0]), 64'd1);
    tick();
    check("t6_sample", 64'(voice_sample[31:16]), 64'hC100);

    // Empty slot (table[3] == table[4]) starts and ends without fetching.
    trigger(2'd2, 3'd3);
    step(2);
    check("t7_empty_active", 64'(voice_active[2]), 64'd0);
    step(10);
    v2_reqs = 0;
    foreach (req_id_log[i]) if (req_id_log[i] == 2'd2) v2_reqs++;
    check("t7_empty_noreq", 64'(v2_reqs), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
